// File: rtl/fb_pkg.sv
// Frame-buffer shared definitions: default geometry and frame FSM encoding,
// common to the port arbiter and the UART pixel assembler.
package fb_pkg;

  localparam int FB_ADDR_W     = 18;
  localparam int FB_DATA_W     = 24;
  localparam int FB_NUM_PIXELS = 200000;

  typedef logic [1:0] fb_state_t;

  localparam fb_state_t ST_IDLE    = 2'd0;
  localparam fb_state_t ST_LOADING = 2'd1;
  localparam fb_state_t ST_READY   = 2'd2;

  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

endpackage

// File: rtl/fb_rd_pipe.sv
// Read-return delay line: carries the valid and out-of-range tags of each
// issued read for RD_LAT cycles so they line up with the BRAM output.
module fb_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_oob,
  output logic out_valid,
  output logic out_oob
);

  logic [RD_LAT-1:0] valid_sr;
  logic [RD_LAT-1:0] oob_sr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_sr <= '0;
      oob_sr   <= '0;
    end else begin
      valid_sr[0] <= in_valid;
      oob_sr[0]   <= in_oob;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        oob_sr[i]   <= oob_sr[i-1];
      end
    end
  end

  assign out_valid = valid_sr[RD_LAT-1];
  assign out_oob   = oob_sr[RD_LAT-1];

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port BRAM arbiter between the UART pixel writer and the display
// reader, with a 1-entry write holding register and frame-load tracking.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int NUM_PIXELS = FB_NUM_PIXELS,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              frame_ready,
  output logic              frame_done,
  output logic              err_oob
);

  localparam logic [ADDR_W:0]   PIX_LIMIT = (ADDR_W+1)'(NUM_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  logic              wr_full;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [DATA_W-1:0] bram_din_q;
  logic              last_grant;
  fb_state_t         state;

  logic wr_oob, rd_oob, rd_elig, grant_wr, grant_rd;
  logic pipe_valid, pipe_oob;

  assign wr_oob      = {1'b0, wr_addr} >= PIX_LIMIT;
  assign rd_oob      = {1'b0, rd_addr} >= PIX_LIMIT;
  assign frame_ready = (state == ST_READY);

  // Grants are qualified by rst so nothing is acked or issued in a reset cycle.
  assign rd_elig  = rst && rd_req && frame_ready;
  assign grant_wr = rst && wr_full && (!rd_elig || last_grant == GRANT_RD);
  assign grant_rd = rd_elig && !grant_wr;

  assign wr_ack  = rst && wr_req && (!wr_full || grant_wr);
  assign rd_ack  = grant_rd;
  assign bram_en = grant_wr || (grant_rd && !rd_oob);
  assign bram_we = grant_wr;

  assign bram_addr = grant_wr ? wr_addr_q : (bram_en ? rd_addr : bram_addr_q);
  assign bram_din  = grant_wr ? wr_data_q : bram_din_q;

  // NOTE: every register here is state, so all use non-blocking assignment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_full     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      last_grant  <= GRANT_RD;
      state       <= ST_IDLE;
      frame_done  <= 1'b0;
      err_oob     <= 1'b0;
    end else begin
      if (wr_ack) begin
        wr_full <= !wr_oob;
        if (!wr_oob) begin
          wr_addr_q <= wr_addr;
          wr_data_q <= wr_data;
        end
      end else if (grant_wr) begin
        wr_full <= 1'b0;
      end

      if (grant_wr)      last_grant <= GRANT_WR;
      else if (grant_rd) last_grant <= GRANT_RD;

      if (bram_en)  bram_addr_q <= bram_addr;
      if (grant_wr) bram_din_q  <= wr_data_q;

      err_oob <= err_oob || (wr_ack && wr_oob) || (grant_rd && rd_oob);

      frame_done <= grant_wr && (wr_addr_q == LAST_ADDR) && (state != ST_READY);

      if (grant_wr) begin
        case (state)
          ST_IDLE, ST_LOADING:
            state <= (wr_addr_q == LAST_ADDR) ? ST_READY : ST_LOADING;
          ST_READY:
            if (wr_addr_q == '0) state <= ST_LOADING;
          default:
            state <= ST_IDLE;
        endcase
      end
    end
  end

  fb_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (grant_rd),
    .in_oob   (rd_oob),
    .out_valid(pipe_valid),
    .out_oob  (pipe_oob)
  );

  assign rd_valid = pipe_valid;
  assign rd_data  = (pipe_valid && !pipe_oob) ? bram_dout : '0;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scenario bench for fb_port_arbiter: a small frame, a BRAM model with
// RD_LAT-cycle read latency, and a read-return scoreboard.
module tb_fb_port_arbiter;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 24;
  localparam int NUM    = 64;
  localparam int RD_LAT = 2;
  localparam logic [ADDR_W-1:0] NUM_A  = ADDR_W'(NUM);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NUM - 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_req, rd_req;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack, rd_ack, rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din, bram_dout;
  logic              frame_ready, frame_done, err_oob;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  fb_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_PIXELS(NUM), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout),
    .frame_ready(frame_ready), .frame_done(frame_done), .err_oob(err_oob)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // BRAM model: writes at the edge, reads return RD_LAT (=2) cycles later.
  logic [DATA_W-1:0] mem [NUM];
  logic [DATA_W-1:0] shadow [NUM];
  logic [DATA_W-1:0] rd_s1 = '0, rd_s2 = '0;

  always @(posedge clk) begin
    if (bram_en && bram_we && bram_addr < NUM_A) mem[int'(bram_addr)] <= bram_din;
    if (bram_en && !bram_we) rd_s1 <= (bram_addr < NUM_A) ? mem[int'(bram_addr)] : '1;
    rd_s2 <= rd_s1;
  end
  assign bram_dout = rd_s2;

  // Read scoreboard: expectation pushed on rd_ack, popped on rd_valid.
  typedef struct { int due; logic [DATA_W-1:0] data; } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      sb.delete();
    end else begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        n_total++;
        $display("FAIL rd_missing: no rd_valid at cycle %0d, expected one", sb[0].due);
        void'(sb.pop_front());
      end
      if (rd_valid) begin
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL rd_unexpected: rd_valid=1 at cycle %0d, expected 0", cyc);
        end else begin
          e = sb.pop_front();
          if (e.due != cyc || rd_data !== e.data)
            $display("FAIL rd_return: cycle %0d data %0h, expected cycle %0d data %0h",
                     cyc, rd_data, e.due, e.data);
          else n_pass++;
        end
      end
      if (rd_ack) begin
        e.due  = cyc + RD_LAT;
        e.data = (rd_addr >= NUM_A) ? '0 : shadow[int'(rd_addr)];
        sb.push_back(e);
      end
    end
  end

  // Streams writes first..last_a, optionally holding a read the whole time.
  task automatic load_range(input int first, input int last_a, input logic hold_rd,
                            input logic [ADDR_W-1:0] raddr,
                            output int n_done, output int done_cyc, output int last_issue,
                            output int early_acks, output int late_acks, output logic rdy_at_done);
    int a = first;
    int post = 0;
    n_done = 0; done_cyc = -1; last_issue = -1;
    early_acks = 0; late_acks = 0; rdy_at_done = 1'b0;
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = ADDR_W'(a); wr_data = DATA_W'($urandom);
    rd_req = hold_rd; rd_addr = raddr;
    for (int guard = 0; guard < 4 * (last_a - first + 1) + 40; guard++) begin
      @(negedge clk);
      if (frame_done) begin n_done++; done_cyc = cyc; rdy_at_done = frame_ready; end
      if (rd_ack) begin
        if (done_cyc < 0) early_acks++; else late_acks++;
      end
      if (bram_en && bram_we && bram_addr == LAST_A) last_issue = cyc;
      if (wr_req && wr_ack) begin shadow[a] = wr_data; a++; end
      if (a > last_a) post++;
      if (post == 5) break;
      @(posedge clk); #1;
      if (a > last_a) wr_req = 1'b0;
      else if (wr_addr != ADDR_W'(a)) begin wr_addr = ADDR_W'(a); wr_data = DATA_W'($urandom); end
    end
    if (post < 5) begin
      n_total++;
      $display("FAIL load_timeout: wrote up to %0d, expected %0d", a - 1, last_a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_req = 1'b1; rd_req = 1'b1; wr_addr = '0; rd_addr = '0; wr_data = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({wr_ack, rd_ack, rd_valid, bram_en, bram_we, frame_ready, frame_done, err_oob} !== 8'h0)
      $display("FAIL reset_flags: got %b, expected 00000000",
               {wr_ack, rd_ack, rd_valid, bram_en, bram_we, frame_ready, frame_done, err_oob});
    else n_pass++;
    n_total++;
    if ({rd_data, bram_addr, bram_din} !== '0)
      $display("FAIL reset_buses: rd_data %0h addr %0h din %0h, expected 0", rd_data, bram_addr, bram_din);
    else n_pass++;
    @(posedge clk); #1;
    wr_req = 1'b0; rd_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({wr_ack, rd_ack, bram_en, frame_ready} !== 4'h0)
      $display("FAIL idle_after_reset: got %b, expected 0000", {wr_ack, rd_ack, bram_en, frame_ready});
    else n_pass++;
  endtask

  task automatic test_first_write();
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = '0; wr_data = 24'h0000FF;
    @(negedge clk);
    n_total++;
    if ({wr_ack, bram_en} !== 2'b10)
      $display("FAIL first_ack: wr_ack,bram_en %b, expected 10", {wr_ack, bram_en});
    else n_pass++;
    shadow[0] = 24'h0000FF;
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bram_en, bram_we} !== 2'b11 || bram_addr !== '0 || bram_din !== 24'h0000FF)
      $display("FAIL first_issue: en/we %b addr %0h din %0h, expected 11 0 ff",
               {bram_en, bram_we}, bram_addr, bram_din);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (frame_ready !== 1'b0 || bram_en !== 1'b0 || bram_din !== 24'h0000FF)
      $display("FAIL loading_hold: ready %b en %b din %0h, expected 0 0 ff", frame_ready, bram_en, bram_din);
    else n_pass++;
  endtask

  task automatic check_load(input string tag, input int n_done, input int done_cyc, input int last_issue,
                            input int early, input int late, input logic rdy);
    n_total++;
    if (n_done != 1 || done_cyc != last_issue + 1 || rdy !== 1'b1)
      $display("FAIL %s_done: pulses %0d at %0d ready %b, expected 1 at %0d ready 1",
               tag, n_done, done_cyc, rdy, last_issue + 1);
    else n_pass++;
    n_total++;
    if (early != 0 || late == 0)
      $display("FAIL %s_rd_block: acks before ready %0d after %0d, expected 0 and >0", tag, early, late);
    else n_pass++;
  endtask

  task automatic test_load_frame();
    int nd, dc, li, ea, la;
    logic rdy;
    load_range(0, NUM - 1, 1'b1, ADDR_W'(5), nd, dc, li, ea, la, rdy);
    check_load("load", nd, dc, li, ea, la, rdy);
    @(posedge clk); #1;
    rd_req = 1'b0;
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = ADDR_W'(20);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_ack) acks++;
      @(posedge clk); #1;
      rd_addr = rd_addr + 1'b1;
    end
    rd_req = 1'b0;
    n_total++;
    if (acks != 8) $display("FAIL b2b_acks: got %0d, expected 8", acks);
    else n_pass++;
    repeat (RD_LAT + 2) @(negedge clk);
    n_total++;
    if (sb.size() != 0) $display("FAIL b2b_drain: %0d outstanding, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_arbitrate();
    int wa = 40;
    int ra = 10;
    int gaps = 0;
    int flips = 0;
    logic prev_we = 1'b0;
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = ADDR_W'(ra);
    wr_req = 1'b1; wr_addr = ADDR_W'(wa); wr_data = DATA_W'($urandom);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bram_en !== 1'b1) gaps++;
      if (i > 0 && bram_we === prev_we) flips++;
      prev_we = bram_we;
      if (wr_ack) begin shadow[wa] = wr_data; wa++; end
      if (rd_ack) ra++;
      @(posedge clk); #1;
      if (wr_addr != ADDR_W'(wa)) begin wr_addr = ADDR_W'(wa); wr_data = DATA_W'($urandom); end
      rd_addr = ADDR_W'(ra);
    end
    wr_req = 1'b0; rd_req = 1'b0;
    n_total++;
    if (gaps != 0) $display("FAIL arb_busy: %0d idle cycles, expected 0", gaps);
    else n_pass++;
    n_total++;
    if (flips != 0) $display("FAIL arb_alternate: %0d repeats of same op, expected 0", flips);
    else n_pass++;
    repeat (RD_LAT + 2) @(negedge clk);
    n_total++;
    if (sb.size() != 0) $display("FAIL arb_drain: %0d outstanding, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_oob();
    int ack_c = -1;
    int val_c = -1;
    logic we_seen = 1'b0;
    logic [DATA_W-1:0] val_d = '1;
    n_total++;
    if (err_oob !== 1'b0) $display("FAIL oob_clear: err_oob %b, expected 0", err_oob);
    else n_pass++;
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = NUM_A; wr_data = 24'hABCDEF;
    @(negedge clk);
    n_total++;
    if (wr_ack !== 1'b1) $display("FAIL oob_wr_ack: got %b, expected 1", wr_ack);
    else n_pass++;
    @(posedge clk); #1;
    wr_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bram_en && bram_we) we_seen = 1'b1;
    end
    n_total++;
    if (we_seen !== 1'b0 || err_oob !== 1'b1)
      $display("FAIL oob_wr: bram_we seen %b err_oob %b, expected 0 1", we_seen, err_oob);
    else n_pass++;
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = 18'h3FFFF;
    @(negedge clk);
    if (rd_ack) ack_c = cyc;
    @(posedge clk); #1;
    rd_req = 1'b0;
    repeat (RD_LAT + 2) begin
      @(negedge clk);
      if (rd_valid && val_c < 0) begin val_c = cyc; val_d = rd_data; end
    end
    n_total++;
    if (ack_c < 0 || val_c != ack_c + RD_LAT || val_d !== '0)
      $display("FAIL oob_rd: ack %0d valid %0d data %0h, expected valid at ack+%0d data 0",
               ack_c, val_c, val_d, RD_LAT);
    else n_pass++;
    n_total++;
    if (err_oob !== 1'b1) $display("FAIL oob_sticky: err_oob %b, expected 1", err_oob);
    else n_pass++;
  endtask

  task automatic test_new_frame();
    int nd, dc, li, ea, la;
    logic rdy;
    logic [DATA_W-1:0] d = DATA_W'($urandom);
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = '0; wr_data = d;
    @(negedge clk);
    if (wr_ack) shadow[0] = d;
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (!(bram_en && bram_we && bram_addr == '0) || frame_ready !== 1'b1)
      $display("FAIL nf_issue: en/we %b addr %0h ready %b, expected 11 0 1",
               {bram_en, bram_we}, bram_addr, frame_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (frame_ready !== 1'b0) $display("FAIL nf_drop: frame_ready %b, expected 0", frame_ready);
    else n_pass++;
    load_range(1, NUM - 1, 1'b1, ADDR_W'(3), nd, dc, li, ea, la, rdy);
    check_load("reload", nd, dc, li, ea, la, rdy);
    @(posedge clk); #1;
    rd_req = 1'b0;
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = ADDR_W'(7);
    wr_req = 1'b1; wr_addr = ADDR_W'(9); wr_data = 24'h555555;
    @(negedge clk);
    n_total++;
    if ({rd_ack, wr_ack} !== 2'b11) $display("FAIL rm_setup: rd_ack,wr_ack %b, expected 11", {rd_ack, wr_ack});
    else n_pass++;
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0; rst = 1'b0;
    @(negedge clk);
    if (bram_en) bad++;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rd_valid || bram_we || frame_done || frame_ready || rd_data != '0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL rm_discard: %0d cycles with activity, expected 0", bad);
    else n_pass++;
    n_total++;
    if (err_oob !== 1'b0) $display("FAIL rm_err_clear: err_oob %b, expected 0", err_oob);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < NUM; i++) begin mem[i] = '0; shadow[i] = '0; end
    test_reset();
    test_first_write();
    test_load_frame();
    test_back_to_back();
    test_arbitrate();
    test_oob();
    test_new_frame();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
